// File: rtl/dma_read_engine.sv
// dma_read_engine
//   Copies a byte-length region from DRAM to the global buffer (GLB) one
//   32-bit word at a time. A descriptor (src, dst, len) is taken in IDLE.
//   RUN issues word reads and writes returned data into a small FIFO that
//   drains straight into the GLB. DONE raises a one-cycle interrupt and
//   then returns to IDLE.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_valid_i/ready_o, cmd_src_i, cmd_dst_i, cmd_len_i : descriptor handshake
//   rd_req_o, rd_addr_o, rd_gnt_i                        : DRAM read request
//   rd_rvalid_i, rd_rdata_i                              : in-order read data
//   glb_we_o, glb_addr_o, glb_wdata_o, glb_wstrb_o       : GLB write port
//   dma_interrupt_o   one-cycle done pulse
//   busy_o            transfer in progress (RUN or DONE)
module dma_read_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_src_i,
  input  logic [31:0] cmd_dst_i,
  input  logic [31:0] cmd_len_i,
  output logic        rd_req_o,
  output logic [31:0] rd_addr_o,
  input  logic        rd_gnt_i,
  input  logic        rd_rvalid_i,
  input  logic [31:0] rd_rdata_i,
  output logic        glb_we_o,
  output logic [31:0] glb_addr_o,
  output logic [31:0] glb_wdata_o,
  output logic [3:0]  glb_wstrb_o,
  output logic        dma_interrupt_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;

  logic [31:0]   src_q;
  logic [31:0]   dst_q;
  logic [30:0]   words_q;
  logic [1:0]    len_lo_q;
  logic [30:0]   req_cnt;
  logic [30:0]   wr_cnt;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [FIFO_DEPTH];

  logic          accept;
  logic          grant;
  logic          push;
  logic          pop;
  logic          last_word;
  logic [CW:0]   occupancy;

  // Byte strobes for the word being written: only the final word of a
  // transfer whose length is not a multiple of four is partial.
  function automatic logic [3:0] word_strb(input logic last, input logic [1:0] len_lo);
    logic [3:0] s;
    s = 4'b1111;
    if (last) begin
      case (len_lo)
        2'b01:   s = 4'b0001;
        2'b10:   s = 4'b0011;
        2'b11:   s = 4'b0111;
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign grant     = rd_req_o && rd_gnt_i;
  // A response with nothing outstanding is stale (e.g. from before a reset).
  assign push      = rd_rvalid_i && (outst_q != '0);
  assign pop       = (fifo_cnt != '0);
  assign last_word = (wr_cnt == words_q - 31'd1);

  // Words already requested but not yet written; capping it at the FIFO
  // depth guarantees every returning word has a free FIFO slot.
  assign occupancy = {1'b0, outst_q} + {1'b0, fifo_cnt};

  assign rd_req_o  = (state == RUN) && (req_cnt != words_q) &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));
  assign rd_addr_o = src_q + {req_cnt[29:0], 2'b00};

  assign glb_we_o    = pop;
  assign glb_addr_o  = dst_q + {wr_cnt[29:0], 2'b00};
  assign glb_wdata_o = pop ? mem[rd_ptr] : 32'd0;
  assign glb_wstrb_o = pop ? word_strb(last_word, len_lo_q) : 4'b0000;

  always_comb begin
    state_nxt       = state;
    cmd_ready_o     = 1'b0;
    busy_o          = 1'b0;
    dma_interrupt_o = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (accept) begin
          state_nxt = (cmd_len_i == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (pop && last_word) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_o          = 1'b1;
        dma_interrupt_o = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      words_q  <= '0;
      len_lo_q <= '0;
      req_cnt  <= '0;
      wr_cnt   <= '0;
      outst_q  <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        src_q    <= cmd_src_i & 32'hFFFF_FFFC;
        dst_q    <= cmd_dst_i & 32'hFFFF_FFFC;
        // 33-bit add so lengths near 2^32 round up without overflow.
        words_q  <= 31'(({1'b0, cmd_len_i} + 33'd3) >> 2);
        len_lo_q <= cmd_len_i[1:0];
        req_cnt  <= '0;
        wr_cnt   <= '0;
      end

      if (grant) begin
        req_cnt <= req_cnt + 31'd1;
      end
      if (pop) begin
        wr_cnt <= wr_cnt + 31'd1;
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      case ({grant, push})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage carries data only; it needs no reset because the count
  // and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rd_rdata_i;
    end
  end

endmodule
